eh2_posit_enc: RTL and testbench
================================

// Module: eh2_posit_enc
// PURPOSE
//  Packs unpacked posit fields (sign, signed regime k, exponent, fraction+GRS) into a POSIT_LEN word.
//  Rounds to nearest even, saturates and applies sign. Sits after eh2_posit_mul / add datapaths.
//  Two-stage valid/ready pipeline: one result per cycle, stall-safe.
// PARAMETERS
//  POSIT_LEN   16                   posit word width N
//  ES          2                    exponent field width
//  REGIME_BW   $clog2(POSIT_LEN)    width of signed (two's complement) regime value k
//  FRAC_W_GRS  POSIT_LEN-ES         fraction width: hidden bit stripped, MSB first; LSB is sticky
// PORTS
//  clk              in   1            clock
//  rst              in   1            synchronous reset, active-high
//  in_valid         in   1            input fields valid
//  in_ready         out  1            encoder accepts input this cycle
//  in_sgn           in   1            sign of result
//  in_reg           in   REGIME_BW    signed regime k
//  in_exp           in   ES           exponent field
//  in_fra           in   FRAC_W_GRS   fraction; bits below the kept field are guard then sticky
//  in_oflw_or_uflw  in   1            scale out of range; direction = in_reg[REGIME_BW-1] (0 = ovf, 1 = unf)
//  in_zero          in   1            result is exact zero
//  in_nar           in   1            result is NaR
//  out_valid        out  1            out_posit valid
//  out_ready        in   1            downstream accepts
//  out_posit        out  POSIT_LEN    encoded posit
// BEHAVIOUR
//  Reset: s1/s2 valid = 0, out_valid = 0, out_posit = 0. in_ready = 1 the cycle after reset.
//  Handshake:
//   - Transfer on valid & ready.
//   - out_posit/out_valid stay stable while out_valid & !out_ready.
//   - s2 loads when !s2_valid | out_ready.
//   - s1 advances when s2 loads.
//   - in_ready = !s1_valid | s1 advances. Combinational from out_ready, no comb path from in_valid.
//  Latency: 2 cycles from input transfer to out_valid with no stall. Throughput 1/cycle.
//  Stage 1 (body build):
//   - k >= 0: regime = (k+1) ones then a zero. k < 0: (-k) zeros then a one.
//   - body = {regime, exp, fra}, left-aligned.
//   - Keep the top N-1 bits. Next bit = G. OR of all remaining bits incl. in_fra[0] = S.
//   - Register kept, G, S, sgn and special flags.
//  Stage 2 (round, sat, sign):
//   - RNE: up = G & (S | kept[0]).
//   - mag = kept + up. If the sum carries into bit N-1, mag = MAXPOS_MAG.
//   - If mag == 0 and input nonzero, mag = 1 (never round to zero).
//   - out = sgn ? -{1'b0,mag} : {1'b0,mag} (two's complement over N bits).
//  Specials, priority nar > zero > oflw_or_uflw > normal:
//   - NaR -> 1<<(N-1).
//   - zero -> 0 (sign ignored).
//   - ovf -> +/-maxpos. unf -> +/-minpos.
//  Regime run longer than N-1 bits is clamped to the saturation value; no wrap.
//  Reset mid-operation: all in-flight results are dropped; out_valid = 0 on the next edge.
//   No output is produced for inputs accepted before reset.
//  Simultaneous in transfer and out transfer with both stages full: pipeline shifts, no bubble, no loss.
// STRUCTURE
//  eh2_posit_pkg:
//   - Derived widths from POSIT_LEN/ES.
//   - Constants NAR, ZERO, MAXPOS, MINPOS.
//   - typedef posit_fields_t {sgn, reg, exp, fra, oflw_or_uflw, zero, nar}.
//  Sub-module eh2_posit_round: combinational stage-2 RNE + saturation + negate. Instanced once.
//  Top holds the two pipeline registers, the handshake and the stage-1 regime shifter.
// TESTING (N=16, ES=2, out_ready=1 unless noted)
//  1. k=0, exp=0, fra=0, sgn=0 -> 0x4000 two cycles after transfer; sgn=1 -> 0xC000.
//  2. k=0, exp=0, fra=14'b00000000001_100 (tie, odd) -> 0x4002; fra=14'b00000000000_100 (tie, even) -> 0x4000.
//  3. oflw_or_uflw=1, in_reg=4'b0111 -> 0x7FFF; in_reg=4'b1000, sgn=1 -> 0xFFFF (-minpos).
//  4. nar=1 with zero=1 -> 0x8000. zero=1, sgn=1 -> 0x0000.
//  5. Stream 4 back-to-back inputs, hold out_ready=0 for 3 cycles:
//     in_ready=0 once both stages are full; outputs stable; all 4 delivered in order, none duplicated.
//  6. Assert rst with both stages full -> out_valid=0 next cycle, in_ready=1, no stale output afterwards.

Source files
------------

// File: rtl/eh2_posit_pkg.sv
// Shared widths, special encodings and field bundles for the posit encoder.
// All widths derive from POSIT_LEN and ES.
package eh2_posit_pkg;

  localparam int POSIT_LEN  = 16;
  localparam int ES         = 2;
  localparam int REGIME_BW  = $clog2(POSIT_LEN);
  localparam int FRAC_W_GRS = POSIT_LEN - ES;
  localparam int KEEP_W     = POSIT_LEN - 1;
  // Headroom below the fraction so the longest regime run never pushes bits out.
  localparam int PAD_W      = 1 << (REGIME_BW - 1);
  localparam int BODY_W     = 2 + ES + FRAC_W_GRS + PAD_W;

  localparam logic [POSIT_LEN-1:0] NAR    = {1'b1, {(POSIT_LEN-1){1'b0}}};
  localparam logic [POSIT_LEN-1:0] ZERO   = {POSIT_LEN{1'b0}};
  localparam logic [POSIT_LEN-1:0] MAXPOS = {1'b0, {(POSIT_LEN-1){1'b1}}};
  localparam logic [POSIT_LEN-1:0] MINPOS = {{(POSIT_LEN-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                  sgn;
    logic [REGIME_BW-1:0]  regime;
    logic [ES-1:0]         exp;
    logic [FRAC_W_GRS-1:0] fra;
    logic                  oflw_or_uflw;
    logic                  zero;
    logic                  nar;
  } posit_fields_t;

  typedef struct packed {
    logic [KEEP_W-1:0] kept;
    logic              g;
    logic              s;
    logic              sgn;
    logic              oflw_or_uflw;
    logic              unf;
    logic              zero;
    logic              nar;
  } posit_body_t;

endpackage

// File: rtl/eh2_posit_round.sv
// Stage-2 datapath: round-to-nearest-even, saturation, special values and sign.
// Purely combinational; the top registers its result.
module eh2_posit_round
  import eh2_posit_pkg::*;
(
  input  posit_body_t          body,
  output logic [POSIT_LEN-1:0] posit
);

  logic                 up;
  logic [POSIT_LEN-1:0] sum;
  logic [KEEP_W-1:0]    mag_c;
  logic [KEEP_W-1:0]    mag;
  logic [POSIT_LEN-1:0] mag_n;
  logic [POSIT_LEN-1:0] signed_p;

  // Round, clamp, never-to-zero, specials and two's complement negate
  always_comb begin
    up    = body.g & (body.s | body.kept[0]);
    sum   = {1'b0, body.kept} + {{(POSIT_LEN-1){1'b0}}, up};
    mag_c = sum[POSIT_LEN-1] ? MAXPOS[KEEP_W-1:0] : sum[KEEP_W-1:0];
    mag   = (mag_c == {KEEP_W{1'b0}}) ? {{(KEEP_W-1){1'b0}}, 1'b1} : mag_c;
    if (body.oflw_or_uflw) begin
      mag_n = body.unf ? MINPOS : MAXPOS;
    end else begin
      mag_n = {1'b0, mag};
    end
    signed_p = body.sgn ? (~mag_n + {{(POSIT_LEN-1){1'b0}}, 1'b1}) : mag_n;
    if (body.nar) begin
      posit = NAR;
    end else if (body.zero) begin
      posit = ZERO;
    end else begin
      posit = signed_p;
    end
  end

endmodule

// File: rtl/eh2_posit_enc.sv
// Posit encoder: two-stage valid/ready pipeline packing sign/regime/exp/fraction
// into a POSIT_LEN word. Stage 1 builds the body, stage 2 rounds into the output register.
module eh2_posit_enc
  import eh2_posit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sgn,
  input  logic [REGIME_BW-1:0]  in_reg,
  input  logic [ES-1:0]         in_exp,
  input  logic [FRAC_W_GRS-1:0] in_fra,
  input  logic                  in_oflw_or_uflw,
  input  logic                  in_zero,
  input  logic                  in_nar,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [POSIT_LEN-1:0]  out_posit
);

  posit_fields_t            in_f;
  posit_body_t              s1_d;
  posit_body_t              s1_q;
  logic                     s1_valid;
  logic                     s2_load;
  logic [REGIME_BW-1:0]     shamt;
  logic signed [BODY_W-1:0] body_pre;
  logic [BODY_W-1:0]        body_sh;
  logic [POSIT_LEN-1:0]     rnd_posit;

  assign in_f     = {in_sgn, in_reg, in_exp, in_fra, in_oflw_or_uflw, in_zero, in_nar};
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // One run bit plus terminator, then an arithmetic shift replicates the run to full length
  always_comb begin
    shamt    = in_f.regime[REGIME_BW-1] ? ~in_f.regime : in_f.regime;
    body_pre = {~in_f.regime[REGIME_BW-1], in_f.regime[REGIME_BW-1],
                in_f.exp, in_f.fra, {PAD_W{1'b0}}};
    body_sh  = body_pre >>> shamt;
    s1_d.kept         = body_sh[BODY_W-1 -: KEEP_W];
    s1_d.g            = body_sh[BODY_W-1-KEEP_W];
    s1_d.s            = |body_sh[BODY_W-2-KEEP_W:0];
    s1_d.sgn          = in_f.sgn;
    s1_d.oflw_or_uflw = in_f.oflw_or_uflw;
    s1_d.unf          = in_f.regime[REGIME_BW-1];
    s1_d.zero         = in_f.zero;
    s1_d.nar          = in_f.nar;
  end

  eh2_posit_round u_round (
    .body  (s1_q),
    .posit (rnd_posit)
  );

  // Pipeline registers: s1 holds the body, the output register is stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_posit <= {POSIT_LEN{1'b0}};
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_posit <= rnd_posit;
        end
      end
    end
  end

endmodule

// File: tb/tb_eh2_posit_enc.sv
// Self-checking bench for eh2_posit_enc: directed corner cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_eh2_posit_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sgn = 1'b0;
  logic [3:0]  in_reg = 4'd0;
  logic [1:0]  in_exp = 2'd0;
  logic [13:0] in_fra = 14'd0;
  logic        in_oflw_or_uflw = 1'b0;
  logic        in_zero = 1'b0;
  logic        in_nar = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_posit;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  bit          rand_rdy = 1'b0;

  eh2_posit_enc dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_sgn          (in_sgn),
    .in_reg          (in_reg),
    .in_exp          (in_exp),
    .in_fra          (in_fra),
    .in_oflw_or_uflw (in_oflw_or_uflw),
    .in_zero         (in_zero),
    .in_nar          (in_nar),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_posit       (out_posit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Value-level model: build the body as an integer bit string, then round it.
  function automatic logic [15:0] ref_enc(input logic s, input logic [3:0] r, input logic [1:0] e,
                                          input logic [13:0] f, input logic ou, input logic z,
                                          input logic n);
    int k, len, rem;
    longint unsigned body, kept, mag;
    bit g, st;
    if (n) return 16'h8000;
    if (z) return 16'h0000;
    k = int'($signed(r));
    if (ou) begin
      mag = (k >= 0) ? 64'd32767 : 64'd1;
    end else begin
      if (k >= 0) begin
        body = ((64'd1 << (k + 1)) - 64'd1) << 1;
        len  = k + 2;
      end else begin
        body = 64'd1;
        len  = 1 - k;
      end
      body = (body << 16) | (longint'(e) << 14) | longint'(f);
      len  = len + 16;
      rem  = len - 15;
      kept = body >> rem;
      g    = ((body >> (rem - 1)) % 2) == 1;
      st   = (body % (64'd1 << (rem - 1))) != 0;
      mag  = kept + ((g && (st || (kept % 2) == 1)) ? 64'd1 : 64'd0);
      if (mag > 64'd32767) mag = 64'd32767;
      if (mag == 64'd0) mag = 64'd1;
    end
    return s ? 16'(64'd65536 - mag) : 16'(mag);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge, in_valid still high.
  task automatic send(input logic s, input logic [3:0] r, input logic [1:0] e, input logic [13:0] f,
                      input logic ou, input logic z, input logic n, input logic [15:0] want);
    int t = 0;
    in_valid = 1'b1; in_sgn = s; in_reg = r; in_exp = e; in_fra = f;
    in_oflw_or_uflw = ou; in_zero = z; in_nar = n;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", 32'(t), 32'd0);
    else exp_q.push_back(want);
    @(posedge clk); #1;
  endtask

  task automatic send_m(input logic s, input logic [3:0] r, input logic [1:0] e, input logic [13:0] f,
                        input logic ou, input logic z, input logic n);
    send(s, r, e, f, ou, z, n, ref_enc(s, r, e, f, ou, z, n));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Random backpressure driver
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard on transfers, stability while stalled
  initial begin
    logic [15:0] prev_posit = 16'h0;
    bit          prev_stall = 1'b0;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_posit), 32'(prev_posit));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(exp_q.size()), 32'd1);
          end else begin
            w = exp_q.pop_front();
            chk("data", 32'(out_posit), 32'(w));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_posit = out_posit;
      end
    end
  end

  initial begin
    logic        s, ou, z, n;
    logic [3:0]  r;
    logic [1:0]  e;
    logic [13:0] f;
    int          fl, t;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_posit", 32'(out_posit), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // k=0 unit values and two-cycle latency
    send(1'b0, 4'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0, 16'h4000);
    idle();
    @(negedge clk); chk("lat_edge1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_edge2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    send(1'b1, 4'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0, 16'hC000);
    // RNE ties
    send(1'b0, 4'd0, 2'd0, 14'b00000000001100, 1'b0, 1'b0, 1'b0, 16'h4002);
    send(1'b0, 4'd0, 2'd0, 14'b00000000000100, 1'b0, 1'b0, 1'b0, 16'h4000);
    // saturation and specials
    send(1'b0, 4'b0111, 2'd0, 14'd0, 1'b1, 1'b0, 1'b0, 16'h7FFF);
    send(1'b1, 4'b1000, 2'd0, 14'd0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    send(1'b0, 4'd0, 2'd0, 14'd0, 1'b0, 1'b1, 1'b1, 16'h8000);
    send(1'b1, 4'd0, 2'd0, 14'd0, 1'b0, 1'b1, 1'b0, 16'h0000);
    // extreme regimes through the model
    send_m(1'b0, 4'b0111, 2'd3, 14'h3FFF, 1'b0, 1'b0, 1'b0);
    send_m(1'b1, 4'b1000, 2'd3, 14'h3FFF, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (4) @(posedge clk); #1;

    // Stream of four with three stalled cycles
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_m(1'($urandom), 4'(i + 1), 2'(i), 14'($urandom), 1'b0, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    send_m(1'b0, 4'd2, 2'd1, 14'h1234, 1'b0, 1'b0, 1'b0);
    send_m(1'b1, 4'd3, 2'd2, 14'h0F0F, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_posit", 32'(out_posit), 32'd0);
    out_ready = 1'b1;
    repeat (8) @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s  = 1'($urandom);
      r  = 4'($urandom);
      e  = 2'($urandom);
      f  = 14'($urandom);
      fl = int'($urandom_range(0, 15));
      ou = (fl == 0);
      z  = (fl == 1);
      n  = (fl == 2);
      send_m(s, r, e, f, ou, z, n);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle();
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
